servo_slew_scheduler: RTL and testbench
=======================================

Name: servo_slew_scheduler

Overview:
- Multi-channel set-point controller for the servo PWM datapath.
- Accepts target pulse widths (µs) through a valid/ready command port.
- Slews each channel's live pulse width toward its target at a fixed rate, using a slow internal update tick.
- Live widths feed one pwm_channel instance per servo. The block owns sequencing, clamping and limit indication for all channels.

Parameters:
- SYSTEM_CLK, 50000000, input clock frequency in Hz.
- UPDATE_HZ, 100, slew update rate in Hz. Tick period P = SYSTEM_CLK/UPDATE_HZ cycles.
- CHANNELS, 4, number of servo channels (2..16).
- MIN_VAL, 1000, minimum legal pulse width in µs.
- MAX_VAL, 2000, maximum legal pulse width in µs.
- MID_VAL, 1500, reset/home pulse width in µs.
- STEP, 1, maximum µs change per channel per tick (≥1).

Ports:
- clk, in, 1, system clock; all state on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, command can be accepted this cycle.
- cmd_chan, in, CW = clog2(CHANNELS), target channel index.
- cmd_target, in, 16, requested pulse width in µs.
- pulse_widths, out, 16*CHANNELS, live widths; channel i occupies bits [16i+15:16i].
- at_target, out, CHANNELS, live width equals target.
- max_lim, out, CHANNELS, live width equals MAX_VAL.
- min_lim, out, CHANNELS, live width equals MIN_VAL.
- busy, out, 1, scan in progress.

Behaviour:
- Reset (async, immediate, including mid-scan):
  - every live width and target = MID_VAL; tick counter = 0; FSM = IDLE.
  - cmd_ready = 1, busy = 0, at_target = all 1s, max_lim = min_lim = 0.
- Tick divider:
  - counter runs 0..P-1; tick is a 1-cycle pulse when counter = P-1, then counter wraps to 0.
  - Constraint: P ≥ CHANNELS+2. A tick seen while not in IDLE is dropped.
- FSM states:
  - IDLE: on tick → SCAN with idx = 0.
  - SCAN: one channel updated per cycle, idx increments; after idx = CHANNELS-1 → IDLE.
  - busy = 1 exactly in SCAN. A scan lasts CHANNELS cycles.
- Slew rule for channel idx, 16-bit unsigned, no wrap:
  - if cur < tgt: cur += min(STEP, tgt-cur)
  - if cur > tgt: cur -= min(STEP, cur-tgt)
  - else hold.
  - Never overshoots the target.
- Command handshake:
  - cmd_ready = 1 in IDLE, 0 in SCAN. Transfer occurs when cmd_valid && cmd_ready.
  - On transfer, target[cmd_chan] = clamp(cmd_target, MIN_VAL, MAX_VAL) at that edge.
  - cmd_chan ≥ CHANNELS: transferred and discarded.
  - Back-to-back transfers allowed every IDLE cycle; a later write to the same channel overwrites.
- Simultaneous tick and transfer in IDLE:
  - both take effect at the same edge; the following scan uses the new target.
- Flags:
  - at_target, max_lim and min_lim are registered from cur/tgt.
  - They are valid 1 cycle after any cur or tgt change.
- pulse_widths is driven directly from the cur registers, with no extra latency.

Test Plan:
- Use SYSTEM_CLK=1000, UPDATE_HZ=100 (P=10), CHANNELS=4, STEP=2 unless noted.
- Reset:
  - assert rst mid-simulation → all widths 1500, at_target=4'b1111, cmd_ready=1, busy=0 asynchronously.
  - Repeat during SCAN → same result, and no further updates that scan.
- Slew:
  - write ch1 target 1503 → after 1st tick scan ch1=1502, after 2nd tick ch1=1503; at_target[1] rises one cycle later.
  - ch0/2/3 stay 1500 throughout.
- Clamp and limits:
  - write ch0 target 2500 → stored target 2000; after 250 ticks ch0=2000, max_lim[0]=1.
  - Then write ch0 target 0 → target 1000; min_lim[0]=1 after 500 ticks.
- Handshake:
  - hold cmd_valid (ch2, 1600) from the first SCAN cycle → cmd_ready=0 for 4 cycles, no write.
  - Transfer occurs on the first IDLE cycle.
- Tick/command collision:
  - transfer ch0 target 1510 on the tick cycle → ch0=1502 at the end of that scan.
  - An out-of-range cmd_chan (unused in CHANNELS=4; test with CHANNELS=3, chan 3) is ignored: no output changes.

Source files
------------

// File: rtl/servo_slew_scheduler.sv
// ============================================================================
// Module   : servo_slew_scheduler
// Brief    : Multi-channel servo set-point slew scheduler with clamped targets
//            and per-channel limit flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module servo_slew_scheduler #(
    parameter int SYSTEM_CLK = 50000000,
    parameter int UPDATE_HZ  = 100,
    parameter int CHANNELS   = 4,
    parameter int MIN_VAL    = 1000,
    parameter int MAX_VAL    = 2000,
    parameter int MID_VAL    = 1500,
    parameter int STEP       = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [$clog2(CHANNELS)-1:0]   cmd_chan,
    input  logic [15:0]                   cmd_target,
    output logic [16*CHANNELS-1:0]        pulse_widths,
    output logic [CHANNELS-1:0]           at_target,
    output logic [CHANNELS-1:0]           max_lim,
    output logic [CHANNELS-1:0]           min_lim,
    output logic                          busy
);

    localparam int          CW       = $clog2(CHANNELS);
    localparam int          PERIOD   = SYSTEM_CLK / UPDATE_HZ;
    localparam int          CNT_W    = $clog2(PERIOD);
    localparam logic [15:0] C_MIN    = 16'(MIN_VAL);
    localparam logic [15:0] C_MAX    = 16'(MAX_VAL);
    localparam logic [15:0] C_MID    = 16'(MID_VAL);
    localparam logic [15:0] C_STEP   = 16'(STEP);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CW-1:0]    C_IDX_LAST = CW'(CHANNELS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CW-1:0]       r_idx;
    logic [15:0]         r_cur [CHANNELS];
    logic [15:0]         r_tgt [CHANNELS];
    logic [CHANNELS-1:0] r_at_target;
    logic [CHANNELS-1:0] r_max_lim;
    logic [CHANNELS-1:0] r_min_lim;
    logic                w_tick;
    logic                w_xfer;
    logic                w_chan_ok;
    logic [15:0]         w_clamped;

    // Moves cur toward tgt by at most STEP, never past tgt.
    function automatic logic [15:0] slew_step(input logic [15:0] cur, input logic [15:0] tgt);
        logic [15:0] diff;
        diff      = '0;
        slew_step = cur;
        if (cur < tgt) begin
            diff      = tgt - cur;
            slew_step = (diff > C_STEP) ? cur + C_STEP : tgt;
        end else if (cur > tgt) begin
            diff      = cur - tgt;
            slew_step = (diff > C_STEP) ? cur - C_STEP : tgt;
        end
    endfunction

    assign w_tick    = (r_cnt == C_CNT_LAST);
    assign w_xfer    = cmd_valid && cmd_ready;
    assign w_chan_ok = (int'(cmd_chan) < CHANNELS);
    assign w_clamped = (cmd_target < C_MIN) ? C_MIN :
                       (cmd_target > C_MAX) ? C_MAX : cmd_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_tick) w_state_nxt = ST_SCAN;
            ST_SCAN: if (r_idx == C_IDX_LAST) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == ST_SCAN);
        cmd_ready = (r_state == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_at_target <= '1;
            r_max_lim   <= '0;
            r_min_lim   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cur[i] <= C_MID;
                r_tgt[i] <= C_MID;
            end
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            // Ticks arriving mid-scan are simply ignored by the FSM.
            if (r_state == ST_IDLE) begin
                r_idx <= '0;
            end else begin
                r_idx    <= r_idx + 1'b1;
                r_cur[r_idx] <= slew_step(r_cur[r_idx], r_tgt[r_idx]);
            end
            if (w_xfer && w_chan_ok) begin
                r_tgt[cmd_chan] <= w_clamped;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                r_at_target[i] <= (r_cur[i] == r_tgt[i]);
                r_max_lim[i]   <= (r_cur[i] == C_MAX);
                r_min_lim[i]   <= (r_cur[i] == C_MIN);
            end
        end
    end

    assign at_target = r_at_target;
    assign max_lim   = r_max_lim;
    assign min_lim   = r_min_lim;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
            assign pulse_widths[16*g +: 16] = r_cur[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_servo_slew_scheduler.sv
// ============================================================================
// Module   : tb_servo_slew_scheduler
// Brief    : Randomised self-checking bench for servo_slew_scheduler with a
//            cycle-phase reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_servo_slew_scheduler;

    localparam int P   = 10;
    localparam int CH  = 4;
    localparam int STP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_chan;
    logic [15:0] cmd_target;
    logic [63:0] pulse_widths;
    logic [3:0]  at_target, max_lim, min_lim;
    logic        busy;

    logic        rst3;
    logic        cmd_valid3;
    logic        cmd_ready3;
    logic [1:0]  cmd_chan3;
    logic [15:0] cmd_target3;
    logic [47:0] pw3;
    logic [2:0]  at3, max3, min3;
    logic        busy3;

    int checks = 0;
    int errors = 0;

    int         m_cur [CH];
    int         m_tgt [CH];
    logic [3:0] m_at, m_max, m_min;
    int         cyc;
    bit         last_xfer;

    servo_slew_scheduler #(
        .SYSTEM_CLK(1000), .UPDATE_HZ(100), .CHANNELS(4),
        .MIN_VAL(1000), .MAX_VAL(2000), .MID_VAL(1500), .STEP(STP)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chan(cmd_chan), .cmd_target(cmd_target), .pulse_widths(pulse_widths),
        .at_target(at_target), .max_lim(max_lim), .min_lim(min_lim), .busy(busy)
    );

    servo_slew_scheduler #(
        .SYSTEM_CLK(1000), .UPDATE_HZ(100), .CHANNELS(3),
        .MIN_VAL(1000), .MAX_VAL(2000), .MID_VAL(1500), .STEP(STP)
    ) dut3 (
        .clk(clk), .rst(rst3), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_chan(cmd_chan3), .cmd_target(cmd_target3), .pulse_widths(pw3),
        .at_target(at3), .max_lim(max3), .min_lim(min3), .busy(busy3)
    );

    always #5 clk = ~clk;

    // Cycle c (counted from reset release) scans channel c%P when c>=P and c%P<CH.
    function automatic bit m_scan();
        return (cyc >= P) && ((cyc % P) < CH);
    endfunction

    function automatic logic [63:0] m_pw();
        logic [63:0] v;
        for (int i = 0; i < CH; i++) v[16*i +: 16] = 16'(m_cur[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cur[i] = 1500;
            m_tgt[i] = 1500;
        end
        m_at = 4'hF; m_max = 4'h0; m_min = 4'h0; cyc = 0;
    endtask

    task automatic step(input bit v, input int ch, input int t);
        int k;
        bit sc;
        cmd_valid  = v;
        cmd_chan   = 2'(ch);
        cmd_target = 16'(t);
        sc         = m_scan();
        last_xfer  = v && !sc;
        for (int i = 0; i < CH; i++) begin
            m_at[i]  = (m_cur[i] == m_tgt[i]);
            m_max[i] = (m_cur[i] == 2000);
            m_min[i] = (m_cur[i] == 1000);
        end
        if (sc) begin
            k = cyc % P;
            if (m_cur[k] < m_tgt[k])      m_cur[k] += (m_tgt[k] - m_cur[k] > STP) ? STP : m_tgt[k] - m_cur[k];
            else if (m_cur[k] > m_tgt[k]) m_cur[k] -= (m_cur[k] - m_tgt[k] > STP) ? STP : m_cur[k] - m_tgt[k];
        end
        if (last_xfer) m_tgt[ch] = (t < 1000) ? 1000 : (t > 2000) ? 2000 : t;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_cmd(input int ch, input int t);
        int tries = 0;
        do begin
            step(1'b1, ch, t);
            tries++;
        end while (!last_xfer && tries < 20);
        cmd_valid = 1'b0;
        checks++;
        if (!last_xfer) begin
            errors++;
            $display("FAIL write_timeout ch=%0d: no transfer within %0d cycles", ch, tries);
        end
    endtask

    task automatic test_reset();
        write_cmd(1, 1700);
        idle(3 * P);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pulse_widths !== 64'h05DC_05DC_05DC_05DC) begin
            errors++; $display("FAIL reset_widths got=%h exp=%h", pulse_widths, 64'h05DC_05DC_05DC_05DC);
        end
        checks++;
        if ({cmd_ready, busy, at_target, max_lim, min_lim} !== {1'b1, 1'b0, 4'hF, 4'h0, 4'h0}) begin
            errors++; $display("FAIL reset_flags got ready=%b busy=%b at=%b max=%b min=%b exp 1 0 1111 0000 0000",
                               cmd_ready, busy, at_target, max_lim, min_lim);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_slew();
        do_reset();
        step(1'b1, 1, 1503);
        cmd_valid = 1'b0;
        while (cyc < 2 * P) begin
            step(1'b0, 0, 0);
            checks++;
            if (pulse_widths !== m_pw()) begin
                errors++; $display("FAIL slew_track cyc=%0d got=%h exp=%h", cyc, pulse_widths, m_pw());
            end
        end
        checks++;
        if (pulse_widths !== {16'd1500, 16'd1500, 16'd1502, 16'd1500}) begin
            errors++; $display("FAIL slew_tick1 got=%h exp ch1=1502 others 1500", pulse_widths);
        end
        idle(22 - cyc);
        checks++;
        if (pulse_widths[31:16] !== 16'd1503 || at_target[1] !== 1'b0) begin
            errors++; $display("FAIL slew_tick2 got ch1=%0d at1=%b exp 1503 0", pulse_widths[31:16], at_target[1]);
        end
        idle(1);
        checks++;
        if (at_target !== 4'hF) begin
            errors++; $display("FAIL slew_at_target got=%b exp=1111", at_target);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        write_cmd(0, 2500);
        idle(252 * P);
        checks++;
        if (pulse_widths[15:0] !== 16'd2000 || max_lim !== 4'b0001 || min_lim !== 4'b0000) begin
            errors++; $display("FAIL clamp_high got ch0=%0d max=%b min=%b exp 2000 0001 0000",
                               pulse_widths[15:0], max_lim, min_lim);
        end
        write_cmd(0, 0);
        idle(502 * P);
        checks++;
        if (pulse_widths[15:0] !== 16'd1000 || min_lim !== 4'b0001 || max_lim !== 4'b0000 || at_target !== 4'hF) begin
            errors++; $display("FAIL clamp_low got ch0=%0d min=%b max=%b at=%b exp 1000 0001 0000 1111",
                               pulse_widths[15:0], min_lim, max_lim, at_target);
        end
        checks++;
        if (pulse_widths !== m_pw()) begin
            errors++; $display("FAIL clamp_model got=%h exp=%h", pulse_widths, m_pw());
        end
    endtask

    task automatic test_handshake();
        do_reset();
        while (!(m_scan() && (cyc % P) == 0)) step(1'b0, 0, 0);
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL hs_scan_ready i=%0d got ready=%b busy=%b exp 0 1", i, cmd_ready, busy);
            end
            step(1'b1, 2, 1600);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL hs_idle_ready got ready=%b busy=%b exp 1 0", cmd_ready, busy);
        end
        step(1'b1, 2, 1600);
        cmd_valid = 1'b0;
        idle(P + CH + 1);
        checks++;
        if (pulse_widths !== {16'd1500, 16'd1502, 16'd1500, 16'd1500}) begin
            errors++; $display("FAIL hs_write got=%h exp ch2=1502 others 1500", pulse_widths);
        end
    endtask

    task automatic test_collision();
        do_reset();
        while ((cyc % P) != P - 1) step(1'b0, 0, 0);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL coll_ready got=%b exp=1", cmd_ready);
        end
        step(1'b1, 0, 1510);
        cmd_valid = 1'b0;
        idle(1);
        checks++;
        if (pulse_widths[15:0] !== 16'd1502) begin
            errors++; $display("FAIL coll_first got ch0=%0d exp 1502", pulse_widths[15:0]);
        end
        idle(CH - 1);
        checks++;
        if (pulse_widths !== {16'd1500, 16'd1500, 16'd1500, 16'd1502} || busy !== 1'b0) begin
            errors++; $display("FAIL coll_end got=%h busy=%b exp ch0=1502 busy 0", pulse_widths, busy);
        end
    endtask

    task automatic test_reset_midscan();
        do_reset();
        write_cmd(0, 1600);
        write_cmd(3, 1600);
        idle(P + 1 - cyc);
        checks++;
        if (pulse_widths[15:0] !== 16'd1502 || busy !== 1'b1) begin
            errors++; $display("FAIL rms_pre got ch0=%0d busy=%b exp 1502 1", pulse_widths[15:0], busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pulse_widths !== 64'h05DC_05DC_05DC_05DC || busy !== 1'b0 || cmd_ready !== 1'b1 || at_target !== 4'hF) begin
            errors++; $display("FAIL rms_async got=%h busy=%b ready=%b at=%b exp all 1500 0 1 1111",
                               pulse_widths, busy, cmd_ready, at_target);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(3 * P);
        checks++;
        if (pulse_widths !== 64'h05DC_05DC_05DC_05DC || at_target !== 4'hF) begin
            errors++; $display("FAIL rms_after got=%h at=%b exp all 1500 1111", pulse_widths, at_target);
        end
    endtask

    task automatic test_out_of_range();
        rst3 = 1'b1;
        cmd_valid3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b0;
        cmd_valid3 = 1'b1; cmd_chan3 = 2'd3; cmd_target3 = 16'd1900;
        repeat (3) @(negedge clk);
        cmd_valid3 = 1'b0;
        repeat (3 * P) @(negedge clk);
        checks++;
        if (pw3 !== 48'h05DC_05DC_05DC || at3 !== 3'b111 || max3 !== 3'b000 || min3 !== 3'b000) begin
            errors++; $display("FAIL oor_ignored got=%h at=%b max=%b min=%b exp all 1500 111 000 000",
                               pw3, at3, max3, min3);
        end
        while (cmd_ready3 !== 1'b1) @(negedge clk);
        cmd_valid3 = 1'b1; cmd_chan3 = 2'd2; cmd_target3 = 16'd1900;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        repeat (P + 4) @(negedge clk);
        checks++;
        if (pw3 !== {16'd1502, 16'd1500, 16'd1500}) begin
            errors++; $display("FAIL oor_legal got=%h exp ch2=1502 others 1500", pw3);
        end
    endtask

    task automatic test_random();
        int t;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            checks++;
            if (cmd_ready !== !m_scan() || busy !== m_scan()) begin
                errors++; $display("FAIL rnd_ctrl cyc=%0d got ready=%b busy=%b exp %b %b",
                                   cyc, cmd_ready, busy, !m_scan(), m_scan());
            end
            case ($urandom_range(0, 9))
                0:       t = 0;
                1:       t = 65535;
                default: t = $urandom_range(900, 2100);
            endcase
            step(1'($urandom_range(0, 2) == 0), $urandom_range(0, 3), t);
            checks++;
            if (pulse_widths !== m_pw() || at_target !== m_at || max_lim !== m_max || min_lim !== m_min) begin
                errors++; $display("FAIL rnd_state cyc=%0d got pw=%h at=%b max=%b min=%b exp pw=%h at=%b max=%b min=%b",
                                   cyc, pulse_widths, at_target, max_lim, min_lim, m_pw(), m_at, m_max, m_min);
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_chan = '0; cmd_target = '0;
        rst3 = 1'b1; cmd_valid3 = 1'b0; cmd_chan3 = '0; cmd_target3 = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        test_reset();
        test_slew();
        test_clamp();
        test_handshake();
        test_collision();
        test_reset_midscan();
        test_out_of_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
